axis_ramp_generator: RTL and testbench

- Parametrised successor to the free-running AXI-Stream counter.
- Emits a configurable arithmetic ramp (start, step, limit) on an AXI4-Stream master, framed into packets of cfg_length beats with tlast.
- Runs either continuously or one packet per run request.
- Feeds DMA writers and test-pattern paths in the data-acquisition chain.

---
 rtl/axis_ramp_pkg.sv | 12 +
 rtl/axis_ramp_generator_if.sv | 35 +++
 rtl/axis_ramp_step.sv | 23 ++
 rtl/axis_ramp_generator.sv | 130 +++++++++++++
 tb/tb_axis_ramp_generator.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_ramp_pkg.sv
// Shared types and constants for the AXI-Stream ramp generator family.
package axis_ramp_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ramp_state_e;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/axis_ramp_generator_if.sv
// AXI4-Stream channel for the ramp generator; tuser exists only when
// AXIS_RAMP_WRAP_FLAG_EN is defined.
interface axis_ramp_generator_if #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) ();

    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;
`ifdef AXIS_RAMP_WRAP_FLAG_EN
    logic                        tuser;
`endif

    modport master (
        output tdata,
        output tvalid,
        output tlast,
`ifdef AXIS_RAMP_WRAP_FLAG_EN
        output tuser,
`endif
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
`ifdef AXIS_RAMP_WRAP_FLAG_EN
        input  tuser,
`endif
        output tready
    );

endinterface

// File: rtl/axis_ramp_step.sv
// Combinational next-value calculator: value + step, reloading start when the
// widened sum passes the inclusive limit.
module axis_ramp_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic [DATA_WIDTH-1:0] i_step,
    input  logic [DATA_WIDTH-1:0] i_start,
    input  logic [DATA_WIDTH-1:0] i_limit,
    output logic [DATA_WIDTH-1:0] o_next,
    output logic                  o_wrap
);

    logic [DATA_WIDTH:0] w_sum;

    // One extra bit so an overflowing sum still compares above the limit.
    always_comb begin
        w_sum  = {1'b0, i_value} + {1'b0, i_step};
        o_wrap = (w_sum > {1'b0, i_limit});
        o_next = o_wrap ? i_start : w_sum[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/axis_ramp_generator.sv
// Arithmetic ramp source framed into fixed-length AXI-Stream packets.
// Define AXIS_RAMP_WRAP_FLAG_EN to add m_axis.tuser marking wrap-reload beats.
module axis_ramp_generator
    import axis_ramp_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_start,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_limit,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic                        cfg_mode,
    input  logic                        run,
    output logic                        busy,
    axis_ramp_generator_if.master       m_axis
);

    ramp_state_e                 r_state;
    logic                        r_run_d;
    logic [AXIS_TDATA_WIDTH-1:0] r_value;
    logic [AXIS_TDATA_WIDTH-1:0] r_start;
    logic [AXIS_TDATA_WIDTH-1:0] r_step;
    logic [AXIS_TDATA_WIDTH-1:0] r_limit;
    logic [CNTR_WIDTH-1:0]       r_last_idx;
    logic [CNTR_WIDTH-1:0]       r_beat;
    logic                        r_mode;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic                        r_wrap;

    logic [AXIS_TDATA_WIDTH-1:0] w_next;
    logic                        w_wrap;
    logic                        w_hs;
    logic                        w_start_req;
    logic [CNTR_WIDTH-1:0]       w_cfg_last_idx;
    logic [CNTR_WIDTH-1:0]       w_beat_inc;

    axis_ramp_step #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_step (
        .i_value (r_value),
        .i_step  (r_step),
        .i_start (r_start),
        .i_limit (r_limit),
        .o_next  (w_next),
        .o_wrap  (w_wrap)
    );

    always_comb begin
        w_hs           = r_tvalid & m_axis.tready;
        w_start_req    = run & ((cfg_mode == MODE_CONT) | ~r_run_d);
        // A zero length behaves as a one-beat packet.
        w_cfg_last_idx = (cfg_length == '0) ? '0 : cfg_length - CNTR_WIDTH'(1);
        w_beat_inc     = r_beat + CNTR_WIDTH'(1);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= StIdle;
            r_run_d    <= 1'b0;
            r_value    <= '0;
            r_start    <= '0;
            r_step     <= '0;
            r_limit    <= '0;
            r_last_idx <= '0;
            r_beat     <= '0;
            r_mode     <= MODE_CONT;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_run_d <= run;
            unique case (r_state)
                StIdle: begin
                    if (w_start_req) begin
                        r_start    <= cfg_start;
                        r_step     <= cfg_step;
                        r_limit    <= cfg_limit;
                        r_last_idx <= w_cfg_last_idx;
                        r_mode     <= cfg_mode;
                        r_value    <= cfg_start;
                        r_beat     <= '0;
                        r_tlast    <= (w_cfg_last_idx == '0);
                        r_tvalid   <= 1'b1;
                        r_wrap     <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    if (w_hs) begin
                        r_value <= w_next;
                        r_wrap  <= w_wrap;
                        if (r_tlast) begin
                            r_beat <= '0;
                            // Packets always finish; run is only consulted here.
                            if ((r_mode == MODE_SINGLE) || !run) begin
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                                r_wrap   <= 1'b0;
                                r_state  <= StIdle;
                            end else begin
                                r_tlast <= (r_last_idx == '0);
                            end
                        end else begin
                            r_beat  <= w_beat_inc;
                            r_tlast <= (w_beat_inc == r_last_idx);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy          = (r_state == StRun);
    assign m_axis.tdata  = r_value;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;

`ifdef AXIS_RAMP_WRAP_FLAG_EN
    assign m_axis.tuser  = r_wrap;
`else
    logic w_unused_wrap;
    assign w_unused_wrap = r_wrap;
`endif

endmodule

// File: tb/tb_axis_ramp_generator.sv
// Self-checking bench for axis_ramp_generator: vector table, directed corner
// sequences and randomized runs against an arithmetic ramp model.
module tb_axis_ramp_generator;

    localparam int unsigned W = 32;
    localparam int unsigned C = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [W-1:0]  cfg_start;
    logic [W-1:0]  cfg_step;
    logic [W-1:0]  cfg_limit;
    logic [C-1:0]  cfg_length;
    logic          cfg_mode;
    logic          run;
    logic          busy;

    int checks = 0;
    int errors = 0;

    axis_ramp_generator_if #(.AXIS_TDATA_WIDTH(W)) ax ();

    axis_ramp_generator #(
        .AXIS_TDATA_WIDTH (W),
        .CNTR_WIDTH       (C)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_limit  (cfg_limit),
        .cfg_length (cfg_length),
        .cfg_mode   (cfg_mode),
        .run        (run),
        .busy       (busy),
        .m_axis     (ax)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        tr;
        logic        vld;
        logic        chk;
        logic [31:0] data;
        logic        last;
    } vec_t;

    vec_t tab[18];

    function automatic vec_t mk(logic tr, logic vld, logic chk, logic [31:0] d, logic l);
        vec_t v;
        v.tr = tr; v.vld = vld; v.chk = chk; v.data = d; v.last = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [W-1:0] s, input logic [W-1:0] st, input logic [W-1:0] l,
                           input logic [C-1:0] len, input logic mode);
        cfg_start = s; cfg_step = st; cfg_limit = l; cfg_length = len; cfg_mode = mode;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " tvalid"}, ax.tvalid, 0);
        chk({nm, " tlast"}, ax.tlast, 0);
        chk({nm, " tdata"}, ax.tdata, 0);
        chk({nm, " busy"}, busy, 0);
`ifdef AXIS_RAMP_WRAP_FLAG_EN
        chk({nm, " tuser"}, ax.tuser, 0);
`endif
    endtask

    task automatic do_reset();
        run = 1'b0;
        ax.tready = 1'b0;
        areset = 1'b1;
        #3;
        chk_zero("reset");
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    // Waits (bounded) for a handshake and compares that beat.
    task automatic expect_beat(input logic [W-1:0] d, input logic l, input logic u,
                               input string nm);
        int n = 0;
        @(negedge aclk);
        while (!(ax.tvalid && ax.tready) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) begin
            chk({nm, " handshake"}, {63'd0, ax.tvalid && ax.tready}, 1);
        end else begin
            chk({nm, " tdata"}, ax.tdata, d);
            chk({nm, " tlast"}, ax.tlast, l);
`ifdef AXIS_RAMP_WRAP_FLAG_EN
            chk({nm, " tuser"}, ax.tuser, u);
`else
            if (u === 1'bx) $display("unexpected unknown user flag");
`endif
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rs, rst, rl;
        int           rlen, rle, rk, runc;
        bit           done;
        longint unsigned mv, ms;
        longint unsigned vals[$];
        bit           wr[$];
        bit           mw;

        areset = 1'b1;
        run = 1'b0;
        ax.tready = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        // Continuous ramp 0..5, length 4: first free-flowing, then stalls.
        tab[0]  = mk(1, 0, 0, 0, 0);
        tab[1]  = mk(1, 1, 1, 0, 0);
        tab[2]  = mk(1, 1, 1, 1, 0);
        tab[3]  = mk(1, 1, 1, 2, 0);
        tab[4]  = mk(1, 1, 1, 3, 1);
        tab[5]  = mk(1, 1, 1, 4, 0);
        tab[6]  = mk(1, 1, 1, 5, 0);
        tab[7]  = mk(1, 1, 1, 0, 0);
        tab[8]  = mk(1, 1, 1, 1, 1);
        tab[9]  = mk(1, 1, 1, 2, 0);
        tab[10] = mk(0, 1, 1, 3, 0);
        tab[11] = mk(1, 1, 1, 3, 0);
        tab[12] = mk(0, 1, 1, 4, 0);
        tab[13] = mk(1, 1, 1, 4, 0);
        tab[14] = mk(0, 1, 1, 5, 1);
        tab[15] = mk(1, 1, 1, 5, 1);
        tab[16] = mk(0, 1, 1, 0, 0);
        tab[17] = mk(1, 1, 1, 0, 0);

        do_reset();
        set_cfg(0, 1, 5, 4, 0);
        for (int i = 0; i < 18; i++) begin
            ax.tready = tab[i].tr;
            run = 1'b1;
            @(negedge aclk);
            chk($sformatf("vec%0d tvalid", i), ax.tvalid, tab[i].vld);
            chk($sformatf("vec%0d busy", i), busy, tab[i].vld);
            if (tab[i].chk) begin
                chk($sformatf("vec%0d tdata", i), ax.tdata, tab[i].data);
                chk($sformatf("vec%0d tlast", i), ax.tlast, tab[i].last);
            end
            @(posedge aclk);
            #1;
        end

        // Single mode: one packet per run rising edge.
        do_reset();
        set_cfg(0, 1, 100, 3, 1);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(0, 0, 0, "single1 b0");
        expect_beat(1, 0, 0, "single1 b1");
        expect_beat(2, 1, 0, "single1 b2");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk($sformatf("single hold%0d tvalid", i), ax.tvalid, 0);
            chk($sformatf("single hold%0d busy", i), busy, 0);
            @(posedge aclk);
            #1;
        end
        run = 1'b0;
        @(posedge aclk);
        #1;
        run = 1'b1;
        expect_beat(0, 0, 0, "single2 b0");
        expect_beat(1, 0, 0, "single2 b1");
        expect_beat(2, 1, 0, "single2 b2");

        // Run dropped mid-packet: packet still completes.
        do_reset();
        set_cfg(0, 1, 1000, 8, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(0, 0, 0, "drop b0");
        expect_beat(1, 0, 0, "drop b1");
        run = 1'b0;
        for (int i = 2; i < 8; i++)
            expect_beat(i, (i == 7), 0, $sformatf("drop b%0d", i));
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk($sformatf("drop idle%0d tvalid", i), ax.tvalid, 0);
            chk($sformatf("drop idle%0d busy", i), busy, 0);
            @(posedge aclk);
            #1;
        end

        // Asynchronous reset while a tlast beat is stalled.
        do_reset();
        set_cfg(100, 1, 1000, 3, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(100, 0, 0, "arst b0");
        expect_beat(101, 0, 0, "arst b1");
        ax.tready = 1'b0;
        @(negedge aclk);
        chk("arst stalled tlast", ax.tlast, 1);
        #2;
        areset = 1'b1;
        #1;
        chk_zero("arst async");
        @(negedge aclk);
        areset = 1'b0;
        ax.tready = 1'b1;
        expect_beat(100, 0, 0, "arst restart b0");
        expect_beat(101, 0, 0, "arst restart b1");

        // All-ones limit with length 1.
        do_reset();
        set_cfg(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(32'h0, 1, 0, "ones b0");
        expect_beat(32'h8000_0000, 1, 0, "ones b1");
        expect_beat(32'h0, 1, 1, "ones b2");
        expect_beat(32'h8000_0000, 1, 0, "ones b3");

        // Zero step holds the value.
        do_reset();
        set_cfg(7, 0, 9, 2, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(7, 0, 0, "step0 b0");
        expect_beat(7, 1, 0, "step0 b1");
        expect_beat(7, 0, 0, "step0 b2");

        // Start above limit, length 0 treated as 1.
        do_reset();
        set_cfg(50, 3, 10, 0, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(50, 1, 0, "over b0");
        expect_beat(50, 1, 1, "over b1");
        expect_beat(50, 1, 1, "over b2");

        // Wrap reload flagged on the reloaded beat only.
        do_reset();
        set_cfg(10, 7, 30, 8, 0);
        ax.tready = 1'b1;
        run = 1'b1;
        expect_beat(10, 0, 0, "wrap b0");
        expect_beat(17, 0, 0, "wrap b1");
        expect_beat(24, 0, 0, "wrap b2");
        expect_beat(10, 0, 1, "wrap b3");
        do_reset();

        // Randomized continuous runs with random backpressure and cfg noise.
        for (int t = 0; t < 20; t++) begin
            rs   = $urandom_range(0, 20);
            rst  = $urandom_range(0, 9);
            rl   = $urandom_range(0, 60);
            rlen = $urandom_range(0, 6);
            rle  = (rlen == 0) ? 1 : rlen;
            runc = $urandom_range(5, 40);
            vals.delete();
            wr.delete();
            mv = rs;
            ms = rs;
            mw = 1'b0;
            for (int i = 0; i < 400; i++) begin
                vals.push_back(mv);
                wr.push_back(mw);
                if (mv + rst > rl) begin
                    mv = ms;
                    mw = 1'b1;
                end else begin
                    mv = mv + rst;
                    mw = 1'b0;
                end
            end
            set_cfg(rs, rst, rl, rlen[C-1:0], 0);
            run = 1'b1;
            rk = 0;
            done = 1'b0;
            for (int c = 0; c < 400 && !done; c++) begin
                if (c > 0) set_cfg($urandom, $urandom, $urandom, C'($urandom), 1'($urandom));
                if (c == runc) run = 1'b0;
                ax.tready = ($urandom_range(0, 3) != 0);
                @(negedge aclk);
                if (c == 0) chk($sformatf("rnd%0d latency", t), ax.tvalid, 0);
                else if (c <= runc) chk($sformatf("rnd%0d c%0d tvalid", t, c), ax.tvalid, 1);
                if (ax.tvalid) begin
                    chk($sformatf("rnd%0d k%0d tdata", t, rk), ax.tdata, vals[rk]);
                    chk($sformatf("rnd%0d k%0d tlast", t, rk), ax.tlast, (rk % rle) == rle - 1);
`ifdef AXIS_RAMP_WRAP_FLAG_EN
                    chk($sformatf("rnd%0d k%0d tuser", t, rk), ax.tuser, wr[rk]);
`endif
                    if (ax.tready) rk++;
                end else if (c > runc) begin
                    done = 1'b1;
                end
                @(posedge aclk);
                #1;
            end
            chk($sformatf("rnd%0d terminated", t), {63'd0, done}, 1);
            chk($sformatf("rnd%0d whole packets", t), rk % rle, 0);
            chk($sformatf("rnd%0d busy", t), busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
